// File: rtl/vgafb_fmlarb.sv
// Two-master FML 4x64 read arbiter for the VGA framebuffer.
// Master 0 (pixel feed) has fixed priority; a starvation counter bounds master 1's wait.
module vgafb_fmlarb #(
    parameter int unsigned fml_depth    = 26,
    parameter int unsigned starve_limit = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,

    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    output logic                 m0_ack,
    output logic                 m0_dv,

    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    output logic                 m1_ack,
    output logic                 m1_dv,

    output logic [63:0]          m_di,

    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    input  logic                 fml_ack,
    input  logic [63:0]          fml_di
);

    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(starve_limit);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   gnt_q, gnt_d;
    logic [1:0]             beat_q, beat_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;
    logic [fml_depth-1:0]   adr_q, adr_d;
    logic                   stb_q, stb_d;
    logic                   dv0_q, dv0_d;
    logic                   dv1_q, dv1_d;

    logic                   arb_c;
    logic                   win1_c;

    // Arbitration happens when idle and on the last data beat, so bursts chain without a gap.
    assign arb_c  = (state_q == IDLE) || ((state_q == DATA) && (beat_q == 2'd3));
    assign win1_c = m1_stb && (!m0_stb || (starve_q == STARVE_MAX));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        adr_d    = adr_q;
        stb_d    = stb_q;
        dv0_d    = dv0_q;
        dv1_d    = dv1_q;

        case (state_q)
            REQ: begin
                if (fml_ack) begin
                    state_d = DATA;
                    beat_d  = 2'd0;
                    stb_d   = 1'b0;
                    dv0_d   = !gnt_q;
                    dv1_d   = gnt_q;
                end
            end
            DATA: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                    dv0_d   = 1'b0;
                    dv1_d   = 1'b0;
                end
            end
            default: ;
        endcase

        if (arb_c && (m0_stb || m1_stb)) begin
            state_d = REQ;
            gnt_d   = win1_c;
            adr_d   = win1_c ? m1_adr : m0_adr;
            stb_d   = 1'b1;
            dv0_d   = 1'b0;
            dv1_d   = 1'b0;
            if (win1_c) begin
                starve_d = '0;
            end else if (m1_stb && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            beat_q   <= 2'd0;
            starve_q <= '0;
            adr_q    <= '0;
            stb_q    <= 1'b0;
            dv0_q    <= 1'b0;
            dv1_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
            adr_q    <= adr_d;
            stb_q    <= stb_d;
            dv0_q    <= dv0_d;
            dv1_q    <= dv1_d;
        end
    end

    // Acks follow the controller's ack combinationally, steered by the committed grant.
    assign m0_ack  = fml_ack && stb_q && !gnt_q;
    assign m1_ack  = fml_ack && stb_q && gnt_q;
    assign m0_dv   = dv0_q;
    assign m1_dv   = dv1_q;
    assign m_di    = fml_di;
    assign fml_adr = adr_q;
    assign fml_stb = stb_q;

endmodule

// File: tb/tb_vgafb_fmlarb.sv
// Directed bench for vgafb_fmlarb: per-cycle vector table plus contention,
// starvation, reset-abort and starve_limit=1 sequences.
module tb_vgafb_fmlarb;

    localparam int unsigned AW = 26;
    localparam logic [AW-1:0] A1 = 26'h0001000;
    localparam logic [AW-1:0] B1 = 26'h0002000;
    localparam logic [AW-1:0] C0 = 26'h0003000;
    localparam logic [AW-1:0] D0 = 26'h0004000;
    localparam logic [AW-1:0] D1 = 26'h0005000;

    logic          sys_clk;
    logic          sys_rst;
    logic [AW-1:0] m0_adr, m1_adr;
    logic          m0_stb, m1_stb;
    logic          m0_ack, m1_ack, m0_dv, m1_dv;
    logic [63:0]   m_di;
    logic [AW-1:0] fml_adr;
    logic          fml_stb, fml_ack;
    logic [63:0]   fml_di;

    logic          m0_ack2, m1_ack2, m0_dv2, m1_dv2;
    logic [63:0]   m_di2;
    logic [AW-1:0] fml_adr2;
    logic          fml_stb2, fml_ack2;

    int n_vec = 0;
    int n_err = 0;

    vgafb_fmlarb #(.fml_depth(AW), .starve_limit(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_dv(m0_dv),
        .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_dv(m1_dv),
        .m_di(m_di),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_ack(fml_ack), .fml_di(fml_di)
    );

    // Second instance with starve_limit=1 served by an always-immediate memory.
    assign fml_ack2 = fml_stb2;
    vgafb_fmlarb #(.fml_depth(AW), .starve_limit(1)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_ack(m0_ack2), .m0_dv(m0_dv2),
        .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_ack(m1_ack2), .m1_dv(m1_dv2),
        .m_di(m_di2),
        .fml_adr(fml_adr2), .fml_stb(fml_stb2), .fml_ack(fml_ack2), .fml_di(fml_di)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic          s0, s1, ack;
        logic [AW-1:0] a0, a1;
        logic          es, ea0, ea1, ed0, ed1;
        logic [AW-1:0] eadr;
    } vec_t;

    vec_t v[$];

    function automatic void add(logic s0, logic s1, logic ack, logic [AW-1:0] a0, logic [AW-1:0] a1,
                                logic es, logic ea0, logic ea1, logic ed0, logic ed1, logic [AW-1:0] eadr);
        vec_t r;
        r.s0 = s0; r.s1 = s1; r.ack = ack; r.a0 = a0; r.a1 = a1;
        r.es = es; r.ea0 = ea0; r.ea1 = ea1; r.ed0 = ed0; r.ed1 = ed1; r.eadr = eadr;
        v.push_back(r);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        m0_stb = 1'b0; m1_stb = 1'b0; fml_ack = 1'b0;
        m0_adr = '0; m1_adr = '0; fml_di = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        int  cyc, last, g1, g2, bad, n0, model;
        logic exp1;

        // Reset values
        do_reset();
        sys_rst = 1'b1;
        #1;
        check("rst_fml_stb", fml_stb, 0);
        check("rst_fml_adr", fml_adr, 0);
        check("rst_acks", {m0_ack, m1_ack}, 0);
        check("rst_dvs", {m0_dv, m1_dv}, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Vector table: single m1 request, m1 drop during REQ, m0 with immediate ack, contention.
        add(0,0,0, 0, 0,   0,0,0,0,0, 0);
        add(0,1,0, 0, A1,  0,0,0,0,0, 0);
        add(0,1,0, 0, A1,  1,0,0,0,0, A1);
        add(0,1,0, 0, A1,  1,0,0,0,0, A1);
        add(0,1,1, 0, A1,  1,0,1,0,0, A1);
        for (int i = 0; i < 4; i++) add(0,0,0, 0, 0, 0,0,0,0,1, 0);
        add(0,0,0, 0, 0,   0,0,0,0,0, 0);
        add(0,1,0, 0, B1,  0,0,0,0,0, 0);
        add(0,0,0, 0, B1,  1,0,0,0,0, B1);
        add(0,0,0, 0, B1,  1,0,0,0,0, B1);
        add(0,0,0, 0, B1,  1,0,0,0,0, B1);
        add(0,0,1, 0, B1,  1,0,1,0,0, B1);
        for (int i = 0; i < 4; i++) add(0,0,0, 0, 0, 0,0,0,0,1, 0);
        add(0,0,0, 0, 0,   0,0,0,0,0, 0);
        add(1,0,0, C0, 0,  0,0,0,0,0, 0);
        add(1,0,1, C0, 0,  1,1,0,0,0, C0);
        for (int i = 0; i < 4; i++) add(0,0,0, 0, 0, 0,0,0,1,0, 0);
        add(0,0,0, 0, 0,   0,0,0,0,0, 0);
        add(1,1,0, D0, D1, 0,0,0,0,0, 0);
        add(1,1,1, D0, D1, 1,1,0,0,0, D0);
        for (int i = 0; i < 4; i++) add(0,1,0, 0, D1, 0,0,0,1,0, 0);
        add(0,1,1, 0, D1,  1,0,1,0,0, D1);
        for (int i = 0; i < 4; i++) add(0,0,0, 0, 0, 0,0,0,0,1, 0);
        add(0,0,0, 0, 0,   0,0,0,0,0, 0);

        for (int i = 0; i < v.size(); i++) begin
            @(negedge sys_clk);
            m0_stb = v[i].s0; m1_stb = v[i].s1; fml_ack = v[i].ack;
            m0_adr = v[i].a0; m1_adr = v[i].a1;
            fml_di = {$urandom, $urandom};
            #1;
            check($sformatf("row%0d_fml_stb", i), fml_stb, v[i].es);
            check($sformatf("row%0d_m0_ack", i), m0_ack, v[i].ea0);
            check($sformatf("row%0d_m1_ack", i), m1_ack, v[i].ea1);
            check($sformatf("row%0d_m0_dv", i), m0_dv, v[i].ed0);
            check($sformatf("row%0d_m1_dv", i), m1_dv, v[i].ed1);
            check($sformatf("row%0d_m_di", i), m_di, fml_di);
            if (v[i].es) check($sformatf("row%0d_fml_adr", i), fml_adr, v[i].eadr);
        end

        // Reset asserted on beat 1 of a master-0 burst aborts it between clock edges.
        @(negedge sys_clk);
        m0_stb = 1'b1; m1_stb = 1'b1; m0_adr = D0; m1_adr = D1; fml_ack = 1'b0;
        @(negedge sys_clk);
        fml_ack = 1'b1;
        @(negedge sys_clk);
        fml_ack = 1'b0; m0_stb = 1'b0;
        #1;
        check("abort_starve_pre", dut.starve_q, 1);
        @(negedge sys_clk);
        #1;
        check("abort_dv_pre", m0_dv, 1);
        #1;
        sys_rst = 1'b1;
        #1;
        check("abort_fml_stb", fml_stb, 0);
        check("abort_dv", {m0_dv, m1_dv}, 0);
        check("abort_starve", dut.starve_q, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check("abort_lat_idle", fml_stb, 0);
        @(negedge sys_clk);
        #1;
        check("abort_lat_stb", fml_stb, 1);
        check("abort_lat_adr", fml_adr, D1);
        fml_ack = 1'b1;
        #1;
        check("abort_m1_ack", m1_ack, 1);
        @(negedge sys_clk);
        fml_ack = 1'b0; m1_stb = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Master 0 alone for 20 bursts.
        do_reset();
        m0_stb = 1'b1; m0_adr = C0;
        bad = 0; n0 = 0; cyc = 0;
        while (n0 < 20 && cyc < 300) begin
            @(negedge sys_clk);
            fml_ack = fml_stb;
            #1;
            cyc++;
            if (m1_ack || m1_dv || dut.starve_q != 0) bad++;
            if (m0_ack) n0++;
        end
        check("m0only_bursts", n0, 20);
        check("m0only_m1_or_starve", bad, 0);
        m0_stb = 1'b0; fml_ack = 1'b0;

        // Contention: default limit gives m0 x8 then m1; limit 1 alternates.
        do_reset();
        m0_stb = 1'b1; m1_stb = 1'b1; m0_adr = D0; m1_adr = D1;
        g1 = 0; g2 = 0; model = 0; last = -1; cyc = 0;
        while ((g1 < 20 || g2 < 6) && cyc < 400) begin
            @(negedge sys_clk);
            fml_ack = fml_stb;
            #1;
            cyc++;
            if (g1 < 20 && (m0_ack || m1_ack)) begin
                exp1 = ((g1 % 9) == 8);
                check($sformatf("cont%0d_gnt", g1), m1_ack, exp1);
                check($sformatf("cont%0d_adr", g1), fml_adr, exp1 ? D1 : D0);
                if (exp1) model = 0;
                else if (model != 8) model++;
                check($sformatf("cont%0d_starve", g1), dut.starve_q, model);
                if (last >= 0) check($sformatf("cont%0d_period", g1), cyc - last, 5);
                last = cyc;
                g1++;
            end
            if (g2 < 6 && (m0_ack2 || m1_ack2)) begin
                check($sformatf("lim1_%0d_gnt", g2), m1_ack2, (g2 % 2) == 1);
                g2++;
            end
        end
        check("cont_done", g1, 20);
        check("lim1_done", g2, 6);
        m0_stb = 1'b0; m1_stb = 1'b0; fml_ack = 1'b0;
        repeat (6) @(negedge sys_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
